// File: rtl/eth_pcs_tx_sched.sv
// eth_pcs_tx_sched: block scheduler in front of the 64b/66b TX gearbox.
// Encoded blocks are queued in a small FIFO. Each block is presented to the
// scrambler/gearbox as two W_DATA halves. An IDLE control block is inserted
// when the FIFO runs dry or transmission is disabled.
// Optional feature macro: ETH_PCS_TX_SCHED_STATS_EN (data block counter).
module eth_pcs_tx_sched #(
    parameter int W_DATA     = 32,
    parameter int W_SYNC     = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int W_UFL_CNT  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_tx_en,
    input  logic                  i_blk_valid,
    input  logic [W_SYNC-1:0]     i_blk_sync,
    input  logic [2*W_DATA-1:0]   i_blk_data,
    output logic                  o_blk_ready,
    input  logic                  i_gb_clk_en,
    input  logic                  i_gb_trans_cnt,
    output logic [W_SYNC-1:0]     o_sync_data,
    output logic [W_DATA-1:0]     o_scr_data,
    output logic                  o_underflow,
    output logic [W_UFL_CNT-1:0]  o_ufl_cnt,
    output logic [31:0]           o_blk_cnt
);

    localparam int W_PTR = $clog2(FIFO_DEPTH);
    localparam int W_CNT = W_PTR + 1;
    localparam int W_BLK = W_SYNC + 2 * W_DATA;

    localparam logic [W_SYNC-1:0]   IDLE_SYNC = W_SYNC'(2'b10);
    localparam logic [2*W_DATA-1:0] IDLE_DATA = (2 * W_DATA)'(64'h0000_0000_0000_001E);

    typedef enum logic {
        ST_DISABLED = 1'b0,
        ST_RUN      = 1'b1
    } state_t;

    state_t              state;
    logic [W_SYNC-1:0]   cur_sync;
    logic [2*W_DATA-1:0] cur_data;

    logic [W_BLK-1:0]    mem [FIFO_DEPTH];
    logic [W_PTR-1:0]    wr_ptr;
    logic [W_PTR-1:0]    rd_ptr;
    logic [W_CNT-1:0]    count;

    logic                empty;
    logic                full;
    logic                load;
    logic                push;
    logic                pop;
    logic                flush;
    logic [W_BLK-1:0]    head;

    assign empty = (count == '0);
    assign full  = (count == W_CNT'(FIFO_DEPTH));

    // Ready comes only from registered state and occupancy, never from a same-cycle pop.
    assign o_blk_ready = (state == ST_RUN) && !full;

    // A load point is the enabled cycle carrying the second half of a block.
    assign load  = i_gb_clk_en && i_gb_trans_cnt;
    assign push  = i_blk_valid && o_blk_ready;
    assign pop   = load && (state == ST_RUN) && i_tx_en && !empty;
    assign flush = load && ((state == ST_DISABLED) || !i_tx_en);
    assign head  = mem[rd_ptr];

    // Halves toward the gearbox are a pure mux of the registered current block.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        o_sync_data = cur_sync;
        o_scr_data  = cur_data[W_DATA-1:0];
        if (i_gb_trans_cnt) begin
            o_scr_data = cur_data[2*W_DATA-1:W_DATA];
        end
    end

    // FIFO storage: written on accepted pushes only.
    // NOTE: the storage array is deliberately not reset; validity is tracked by count and pointers.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr] <= {i_blk_sync, i_blk_data};
        end
    end

    // FIFO pointers and occupancy; a flush discards everything queued, including a same-cycle push.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + W_PTR'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + W_PTR'(1);
            end
            count <= count + W_CNT'(push) - W_CNT'(pop);
        end
    end

    // Scheduler FSM: at each load point choose the next block and account underflows.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state       <= ST_DISABLED;
            cur_sync    <= IDLE_SYNC;
            cur_data    <= IDLE_DATA;
            o_underflow <= 1'b0;
            o_ufl_cnt   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
            o_underflow <= 1'b0;
            if (load) begin
                case (state)
                    ST_DISABLED: begin
                        cur_sync <= IDLE_SYNC;
                        cur_data <= IDLE_DATA;
                        if (i_tx_en) begin
                            state <= ST_RUN;
                        end
                    end
                    ST_RUN: begin
                        if (!i_tx_en) begin
                            cur_sync <= IDLE_SYNC;
                            cur_data <= IDLE_DATA;
                            state    <= ST_DISABLED;
                        end else if (!empty) begin
                            cur_sync <= head[W_BLK-1:2*W_DATA];
                            cur_data <= head[2*W_DATA-1:0];
                        end else begin
                            cur_sync    <= IDLE_SYNC;
                            cur_data    <= IDLE_DATA;
                            o_underflow <= 1'b1;
                            if (o_ufl_cnt != '1) begin
                                o_ufl_cnt <= o_ufl_cnt + W_UFL_CNT'(1);
                            end
                        end
                    end
                    default: begin
                        state <= ST_DISABLED;
                    end
                endcase
            end
        end
    end

`ifdef ETH_PCS_TX_SCHED_STATS_EN
    logic [31:0] blk_cnt;

    // Wrapping count of data blocks loaded from the FIFO.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            blk_cnt <= '0;
        end else if (pop) begin
            blk_cnt <= blk_cnt + 32'd1;
        end
    end

    assign o_blk_cnt = blk_cnt;
`else
    assign o_blk_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_eth_pcs_tx_sched.sv
// tb_eth_pcs_tx_sched: directed self-checking bench for eth_pcs_tx_sched.
// Encoder blocks carry data {32'hB+n, 32'hA+n}; expected halves are hand-derived.
module tb_eth_pcs_tx_sched;

    logic        i_clk = 1'b0;
    logic        i_reset_n;
    logic        i_tx_en;
    logic        i_blk_valid;
    logic [1:0]  i_blk_sync;
    logic [63:0] i_blk_data;
    logic        o_blk_ready;
    logic        i_gb_clk_en;
    logic        i_gb_trans_cnt;
    logic [1:0]  o_sync_data;
    logic [31:0] o_scr_data;
    logic        o_underflow;
    logic [15:0] o_ufl_cnt;
    logic [31:0] o_blk_cnt;

    int          n_vec = 0;
    int          n_err = 0;

    // Encoder source state and last observed outputs.
    int          enc_left = 0;
    logic [31:0] enc_n = 32'd0;
    logic [1:0]  obs_sync;
    logic [31:0] obs_scr;
    logic        obs_rdy;
    logic        obs_uf;
    logic [15:0] obs_ufl_cnt;
    logic        rdy0;
    logic        rdy1;
    logic [15:0] exp_ufl = 16'd0;
    logic [31:0] exp_blk;

    localparam logic [31:0] IDLE_LO = 32'h0000_001E;
    localparam logic [31:0] IDLE_HI = 32'h0000_0000;

    eth_pcs_tx_sched dut (
        .i_clk          (i_clk),
        .i_reset_n      (i_reset_n),
        .i_tx_en        (i_tx_en),
        .i_blk_valid    (i_blk_valid),
        .i_blk_sync     (i_blk_sync),
        .i_blk_data     (i_blk_data),
        .o_blk_ready    (o_blk_ready),
        .i_gb_clk_en    (i_gb_clk_en),
        .i_gb_trans_cnt (i_gb_trans_cnt),
        .o_sync_data    (o_sync_data),
        .o_scr_data     (o_scr_data),
        .o_underflow    (o_underflow),
        .o_ufl_cnt      (o_ufl_cnt),
        .o_blk_cnt      (o_blk_cnt)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock: drive inputs after the edge, sample at the falling edge.
    task automatic cycle(input logic en, input logic tc);
        logic acc;
        i_gb_clk_en    = en;
        i_gb_trans_cnt = tc;
        i_blk_valid    = (enc_left > 0);
        i_blk_sync     = 2'b01;
        i_blk_data     = {32'hB + enc_n, 32'hA + enc_n};
        @(negedge i_clk);
        obs_sync    = o_sync_data;
        obs_scr     = o_scr_data;
        obs_rdy     = o_blk_ready;
        obs_uf      = o_underflow;
        obs_ufl_cnt = o_ufl_cnt;
        acc         = i_blk_valid && o_blk_ready;
        @(posedge i_clk);
        #1;
        if (acc) begin
            enc_n    = enc_n + 32'd1;
            enc_left = enc_left - 1;
        end
    endtask

    // One block period (two halves), optionally with a pause before the second half.
    task automatic period(input logic [1:0] s, input logic [31:0] lo, input logic [31:0] hi,
                          input logic uf, input logic pause);
        cycle(1'b1, 1'b0);
        rdy0 = obs_rdy;
        check("sync_lo", 64'(obs_sync), 64'(s));
        check("half_lo", 64'(obs_scr), 64'(lo));
        check("underflow", 64'(obs_uf), 64'(uf));
        if (uf && exp_ufl != 16'hFFFF) exp_ufl = exp_ufl + 16'd1;
        check("ufl_cnt", 64'(obs_ufl_cnt), 64'(exp_ufl));
        if (pause) begin
            cycle(1'b0, 1'b1);
            check("pause_sync", 64'(obs_sync), 64'(s));
            check("pause_half", 64'(obs_scr), 64'(hi));
        end
        cycle(1'b1, 1'b1);
        rdy1 = obs_rdy;
        check("sync_hi", 64'(obs_sync), 64'(s));
        check("half_hi", 64'(obs_scr), 64'(hi));
        check("underflow_hi", 64'(obs_uf), 64'd0);
    endtask

    task automatic data_period(input int n, input logic uf, input logic pause);
        logic [31:0] nn;
        nn = 32'(n);
        period(2'b01, 32'hA + nn, 32'hB + nn, uf, pause);
    endtask

    initial begin
        logic gtc;
        logic gen;
        int   m;

        i_reset_n      = 1'b0;
        i_tx_en        = 1'b0;
        i_blk_valid    = 1'b0;
        i_blk_sync     = 2'b00;
        i_blk_data     = 64'd0;
        i_gb_clk_en    = 1'b0;
        i_gb_trans_cnt = 1'b0;

        // Reset state.
        repeat (2) @(posedge i_clk);
        #1;
        check("rst_ready", 64'(o_blk_ready), 64'd0);
        check("rst_sync", 64'(o_sync_data), 64'(2'b10));
        check("rst_lo", 64'(o_scr_data), 64'(IDLE_LO));
        check("rst_underflow", 64'(o_underflow), 64'd0);
        check("rst_ufl_cnt", 64'(o_ufl_cnt), 64'd0);
        check("rst_blk_cnt", 64'(o_blk_cnt), 64'd0);
        i_gb_trans_cnt = 1'b1;
        #1;
        check("rst_hi", 64'(o_scr_data), 64'(IDLE_HI));
        i_reset_n = 1'b1;

        // TX disabled under a 32-of-33 gearbox enable pattern: IDLE only, never ready.
        gtc = 1'b0;
        for (int i = 0; i < 66; i++) begin
            gen = ((i % 33) != 32);
            cycle(gen, gtc);
            check("dis_sync", 64'(obs_sync), 64'(2'b10));
            check("dis_half", 64'(obs_scr), gtc ? 64'(IDLE_HI) : 64'(IDLE_LO));
            check("dis_ready", 64'(obs_rdy), 64'd0);
            if (gen) gtc = ~gtc;
        end
        check("dis_ufl_cnt", 64'(obs_ufl_cnt), 64'd0);

        // Enable and stream 16 blocks at full rate.
        i_tx_en = 1'b1;
        period(2'b10, IDLE_LO, IDLE_HI, 1'b0, 1'b0);
        check("p0_ready", 64'(rdy0), 64'd0);
        enc_left = 16;
        period(2'b10, IDLE_LO, IDLE_HI, 1'b0, 1'b0);
        check("p1_ready", 64'(rdy0), 64'd1);
        for (int n = 0; n < 16; n++) begin
            data_period(n, 1'b0, 1'b0);
            if (n == 2) check("full_ready", 64'(rdy1), 64'd0);
        end
        period(2'b10, IDLE_LO, IDLE_HI, 1'b1, 1'b0);

        // Encoder sends three blocks then stops.
        enc_left = 3;
        period(2'b10, IDLE_LO, IDLE_HI, 1'b1, 1'b0);
        data_period(16, 1'b0, 1'b0);
        data_period(17, 1'b0, 1'b0);
        data_period(18, 1'b0, 1'b0);
        period(2'b10, IDLE_LO, IDLE_HI, 1'b1, 1'b0);
        period(2'b10, IDLE_LO, IDLE_HI, 1'b1, 1'b0);

        // Pause on the second half: hold, and load only on the next enabled boundary.
        enc_left = 2;
        period(2'b10, IDLE_LO, IDLE_HI, 1'b1, 1'b0);
        data_period(19, 1'b0, 1'b1);
        data_period(20, 1'b0, 1'b0);

        // Disable with three blocks queued, then re-enable.
        enc_left = 5;
        period(2'b10, IDLE_LO, IDLE_HI, 1'b1, 1'b0);
        data_period(21, 1'b0, 1'b0);
        i_tx_en = 1'b0;
        data_period(22, 1'b0, 1'b0);
        period(2'b10, IDLE_LO, IDLE_HI, 1'b0, 1'b0);
        check("off_ready", 64'(rdy0), 64'd0);
        i_tx_en = 1'b1;
        period(2'b10, IDLE_LO, IDLE_HI, 1'b0, 1'b0);
        check("reen_ready0", 64'(rdy0), 64'd0);
        enc_left = 1;
        period(2'b10, IDLE_LO, IDLE_HI, 1'b0, 1'b0);
        check("reen_ready1", 64'(rdy0), 64'd1);
        data_period(26, 1'b0, 1'b0);
        period(2'b10, IDLE_LO, IDLE_HI, 1'b1, 1'b0);

        // Every cycle a load point with an empty FIFO: drive the counter to saturation.
        // The last boundary of the previous period already counted one more underflow.
        m = 32'hFFFE - int'(exp_ufl) - 1;
        for (int i = 0; i < m; i++) cycle(1'b1, 1'b1);
        cycle(1'b1, 1'b1);
        check("ufl_near_sat", 64'(obs_ufl_cnt), 64'h0000_FFFE);
        cycle(1'b1, 1'b1);
        check("ufl_sat", 64'(obs_ufl_cnt), 64'h0000_FFFF);
        cycle(1'b1, 1'b1);
        check("ufl_sat_hold", 64'(obs_ufl_cnt), 64'h0000_FFFF);

`ifdef ETH_PCS_TX_SCHED_STATS_EN
        exp_blk = 32'd24;
`else
        exp_blk = 32'd0;
`endif
        check("blk_cnt", 64'(o_blk_cnt), 64'(exp_blk));

        // Reset in the middle of a data block.
        enc_left = 2;
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b1);
        cycle(1'b1, 1'b0);
        check("mid_lo", 64'(obs_scr), 64'(32'hA + 32'd27));
        i_reset_n      = 1'b0;
        i_gb_trans_cnt = 1'b0;
        #1;
        check("mid_rst_sync", 64'(o_sync_data), 64'(2'b10));
        check("mid_rst_lo", 64'(o_scr_data), 64'(IDLE_LO));
        check("mid_rst_ready", 64'(o_blk_ready), 64'd0);
        check("mid_rst_ufl", 64'(o_ufl_cnt), 64'd0);
        check("mid_rst_blk", 64'(o_blk_cnt), 64'd0);
        i_reset_n = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/eth_pcs_tx_sched.md
Name: eth_pcs_tx_sched

Overview:
- Block scheduler that feeds the 64b/66b TX gearbox path.
- Accepts 66-bit encoded blocks from the encoder over a valid/ready handshake and buffers them in a small FIFO.
- Presents each block to the scrambler/gearbox as two 32-bit halves, tracking the gearbox transfer counter and its clk_en stall pattern.
- Inserts an idle control block on underflow or when TX is disabled, and keeps link statistics.

Parameters:
- W_DATA, 32, gearbox transfer width; the block payload is 2*W_DATA.
- W_SYNC, 2, sync header width.
- FIFO_DEPTH, 4, block FIFO entries; power of two, at least 2.
- W_UFL_CNT, 16, width of the underflow counter.

Ports:
- i_clk  in  1  single clock, same domain as the gearbox.
- i_reset_n  in  1  asynchronous active-low reset.
- i_tx_en  in  1  enables data transmission; sampled only at block boundaries.
- i_blk_valid  in  1  encoder block valid.
- i_blk_sync  in  W_SYNC  sync header (2'b01 data, 2'b10 control).
- i_blk_data  in  2*W_DATA  block payload; bits [W_DATA-1:0] are sent first.
- o_blk_ready  out  1  block accepted when i_blk_valid && o_blk_ready.
- i_gb_clk_en  in  1  gearbox clock enable; low means a pause cycle.
- i_gb_trans_cnt  in  1  gearbox transfer index within the block (0 = first half).
- o_sync_data  out  W_SYNC  sync header toward the gearbox.
- o_scr_data  out  W_DATA  payload half toward the scrambler/gearbox.
- o_underflow  out  1  one-cycle pulse when an idle block is inserted in RUN.
- o_ufl_cnt  out  W_UFL_CNT  saturating underflow count.
- o_blk_cnt  out  32  data blocks sent (optional feature).

Behaviour:
- Reset (async assert, sync release):
  - FIFO empty; state DISABLED; current block register cur = IDLE block; o_underflow = 0; o_ufl_cnt = 0; o_blk_cnt = 0.
  - o_blk_ready = 0.
  - IDLE block: sync 2'b10, data 64'h0000_0000_0000_001E (type 0x1E, eight /I/ codes of 0x00).
- Outputs are combinational muxes of registered cur only, selected by i_gb_trans_cnt:
  - When 0: o_sync_data = cur.sync, o_scr_data = cur.data[31:0].
  - When 1: o_sync_data = cur.sync, o_scr_data = cur.data[63:32].
  - No other combinational input-to-output paths.
- Block boundary (load point): a cycle with i_gb_clk_en = 1 and i_gb_trans_cnt = 1. cur is reloaded on the next edge. No other cycle changes cur.
- Pause cycles (i_gb_clk_en = 0): cur holds, no load, no pop, no counter update. Pushes are still accepted.
- Push: i_blk_valid && o_blk_ready writes {sync, data} to the FIFO tail.
- o_blk_ready = (state == RUN) && !full. It is derived from registered occupancy, so a push is never accepted while full, even if a pop occurs in the same cycle.
- State machine, evaluated at load points only:
  - DISABLED:
    - cur <= IDLE; FIFO flushed; no underflow accounting.
    - If i_tx_en = 1, go to RUN.
  - RUN, i_tx_en = 0:
    - cur <= IDLE; FIFO flushed (pending blocks discarded); go to DISABLED.
  - RUN, i_tx_en = 1, FIFO non-empty:
    - cur <= head; pop; o_blk_cnt += 1.
  - RUN, i_tx_en = 1, FIFO empty:
    - cur <= IDLE; o_underflow pulses for one cycle (the cycle after the load point).
    - o_ufl_cnt += 1, saturating at all ones.
- Push and load in the same cycle with the FIFO empty: the new block is not bypassed. This counts as an underflow; the block is loaded at the next boundary.
- i_tx_en changes between load points have no effect until the next load point.
- Latency: a block pushed into an empty FIFO in RUN appears on the outputs in the first i_gb_trans_cnt = 0 cycle after the next load point.
- Pointer arithmetic: log2(FIFO_DEPTH)-bit pointers with a separate occupancy counter of width log2(FIFO_DEPTH)+1. Pointers wrap modulo FIFO_DEPTH.
- Reset mid-block: outputs immediately revert to IDLE halves and FIFO contents are lost.

Optional Feature:
- Macro: ETH_PCS_TX_SCHED_STATS_EN.
- Defined: o_blk_cnt is a 32-bit wrapping counter of data blocks loaded from the FIFO, cleared by reset.
- Undefined: o_blk_cnt is tied to 0, no counter logic is instantiated, and all other behaviour is identical.

Test Plan:
- Reset then i_tx_en = 0 for 66 cycles with a gearbox model giving 32 enabled and 1 paused cycle out of every 33 -> o_blk_ready = 0; every half is IDLE (sync 2'b10, first half 32'h0000_001E, second half 32'h0); o_ufl_cnt = 0.
- i_tx_en = 1, encoder streams at full rate, blocks with data = {32'hB+n, 32'hA+n} -> halves A+n then B+n in order, sync 2'b01; no underflow over 16 blocks; o_blk_ready deasserts when 4 blocks are queued.
- Encoder stops after 3 blocks in RUN -> 3 data blocks, then an IDLE block; o_underflow pulses once per idle boundary; o_ufl_cnt = 1, 2, 3 ...
- Pause alignment: i_gb_clk_en low for 1 cycle at trans_cnt = 1 -> cur and outputs hold across the pause, no pop; the load occurs on the following enabled trans_cnt = 1 cycle.
- i_tx_en dropped with 3 blocks queued -> at the next load point cur = IDLE, FIFO empty, o_blk_ready = 0; re-enable -> the first data block follows a push, with no stale blocks.
- Force o_ufl_cnt near 16'hFFFF with prolonged underflow -> saturates at 16'hFFFF; with ETH_PCS_TX_SCHED_STATS_EN, o_blk_cnt equals the number of data blocks observed; without it, o_blk_cnt = 0.
